instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Fetch stage of the pipeline. Issues one 32-bit instruction read at a time to the memory port. Presents each returned instruction, tagged with its PC, on a valid/ready stream. That stream feeds the fetch→decode `skidbuffer` (WIDTH=64, `{pc, instr}`). Accepts a redirect (branch/jump target) from later stages and discards in-flight fetches made stale by it.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: first fetch address after reset; low 2 bits must be 0.

Ports (one clock `clk`; `reset` is synchronous and active-high):
- `clk`  in  1  clock, all logic on posedge
- `reset`  in  1  synchronous, active-high reset
- `mem_valid`  out  1  read request outstanding
- `mem_addr`  out  32  read address, word-aligned
- `mem_ready`  in  1  single-cycle pulse: `mem_rdata` valid, request complete
- `mem_rdata`  in  32  returned instruction
- `redirect_valid`  in  1  single-cycle: restart fetch at `redirect_pc`
- `redirect_pc`  in  32  new PC; bits [1:0] ignored (treated as 0)
- `output_valid`  out  1  `output_data`/`output_pc` hold an instruction
- `output_ready`  in  1  downstream accepts this cycle
- `output_data`  out  32  instruction word
- `output_pc`  out  32  address of `output_data`

## Operation
- The block holds an internal `pc`, the next address to fetch.
- At most one memory request is outstanding.
- States: IDLE, FETCH, DELIVER, DISCARD.
- **Reset** (any state, any cycle):
  - state→IDLE, `pc`←RESET_PC.
  - `mem_valid`=0, `output_valid`=0.
  - `mem_addr`=RESET_PC, `output_data`=0, `output_pc`=0.
  - Any outstanding request is abandoned.
- **IDLE:** `mem_valid`←1, `mem_addr`←`pc`; →FETCH. If `redirect_valid`, use `redirect_pc` instead.
- **FETCH:** `mem_valid` held at 1, `mem_addr` held stable until `mem_ready`.
  - `mem_ready` && !`redirect_valid`:
    - `output_data`←`mem_rdata`, `output_pc`←`mem_addr`, `output_valid`←1.
    - `mem_valid`←0, `pc`←`mem_addr`+4; →DELIVER.
  - `mem_ready` && `redirect_valid`:
    - Data dropped.
    - `mem_addr`←`redirect_pc`, `pc`←`redirect_pc`, `mem_valid` stays 1; stay FETCH.
  - !`mem_ready` && `redirect_valid`: `pc`←`redirect_pc`; →DISCARD. The request cannot be cancelled.
- **DISCARD:** `mem_valid` held at 1.
  - On `mem_ready`: data dropped, `mem_addr`←`pc`; →FETCH.
  - A further redirect overwrites `pc` (last wins). This applies in both of these cases:
    - on the `mem_ready` cycle, `mem_addr`←`redirect_pc`;
    - on a cycle without `mem_ready`, the block stays in DISCARD.
- **DELIVER:** `output_valid`=1; data and PC stable until transfer.
  - `output_valid`&&`output_ready` is a completed transfer, even if `redirect_valid` is high in the same cycle.
  - On transfer: `output_valid`←0, `mem_valid`←1, `mem_addr`←(`redirect_valid` ? `redirect_pc` : `pc`); →FETCH.
  - `redirect_valid` without `output_ready`:
    - Held instruction dropped, `output_valid`←0.
    - `mem_valid`←1, `mem_addr`←`redirect_pc`, `pc`←`redirect_pc`; →FETCH.
- **PC arithmetic:** 32-bit, +4 modulo 2^32; 0xFFFF_FFFC wraps to 0x0000_0000. `mem_addr[1:0]` and `output_pc[1:0]` are always 0.
- **Outputs:** all registered; no combinational path from any input to any output.

## Timing
- Reset released at cycle R: IDLE in R, `mem_valid`=1 with `mem_addr`=RESET_PC from R+1.
- `mem_ready` at cycle N → `output_valid`=1 at N+1.
- Transfer at cycle M → `mem_valid`=1 with the next address at M+1.
- Peak throughput: one instruction per 2 cycles with zero-wait memory. Each memory wait cycle adds one cycle; each backpressure cycle adds one cycle.
- Output stability: if `output_valid` && !`output_ready` at cycle k and no redirect, then at k+1 `output_valid`=1 and `output_data`/`output_pc` are unchanged. This meets the downstream `skidbuffer` input contract.
- Memory stability: `mem_addr` is stable while `mem_valid`=1 and `mem_ready`=0.
- `mem_valid` drops only after `mem_ready`, or on reset.

## Structure
- Shared package `cpu_pkg`:
  - `fetch_state_t` enum (IDLE, FETCH, DELIVER, DISCARD), 2 bits.
  - `XLEN`=32.
  - `PC_STEP`=4.
- Single flat module; no sub-module.
- The `skidbuffer` is instantiated beside this block in the pipeline top, not inside it.
- Formal properties sit under `ifdef FORMAL`:
  - `mem_addr` stability;
  - output stability under backpressure;
  - at most one outstanding request;
  - no `output_valid` in IDLE/FETCH/DISCARD.

## Test plan
- Reset with RESET_PC=0x100; memory answers 2 cycles after request with 0x0000_0013 → request at 0x100; `output_valid`=1 with data 0x13, pc 0x100, one cycle after `mem_ready`; then request at 0x104.
- Hold `output_ready`=0 for 5 cycles in DELIVER → data, pc and `output_valid` constant, `mem_valid`=0 throughout; raise ready → next cycle `mem_valid`=1, `mem_addr`=0x104.
- Redirect to 0x200 while FETCH awaits `mem_ready` → `mem_valid` stays high at the old address; returned word never appears on output; next request at 0x200; first delivered pc=0x200.
- Redirect to 0x200 in the same cycle as `mem_ready` → data dropped; `mem_addr`=0x200 next cycle, no `output_valid` pulse.
- Redirect to 0xFFFF_FFFC, deliver → next `mem_addr`=0x0000_0000.
- Assert reset mid-FETCH and mid-DELIVER → next cycle `mem_valid`=0, `output_valid`=0; after release, refetch from RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU pipeline types and constants
//
// Purpose: types and constants shared by the pipeline stages.
//   XLEN          : datapath / address width
//   PC_STEP       : byte increment between sequential instructions
//   fetch_state_t : instruction fetch stage state encoding
package cpu_pkg;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] PC_STEP = 32'd4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FETCH   = 2'd1,
      DELIVER = 2'd2,
      DISCARD = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - pipeline fetch stage, one outstanding read, redirect aware
//
// Purpose: fetches 32-bit instructions one at a time from a memory port and
// presents each one, tagged with its PC, on a valid/ready stream that feeds
// the fetch->decode skid buffer. A redirect restarts fetch at a new PC; an
// in-flight read that a redirect made stale is waited out and its data dropped.
//
// Ports:
//   clk            in   clock, all logic on posedge
//   reset          in   synchronous active-high reset
//   mem_valid      out  read request outstanding
//   mem_addr       out  [31:0] word-aligned read address
//   mem_ready      in   one-cycle pulse, mem_rdata valid, request complete
//   mem_rdata      in   [31:0] returned instruction
//   redirect_valid in   one-cycle, restart fetch at redirect_pc
//   redirect_pc    in   [31:0] new PC, bits [1:0] ignored
//   output_valid   out  output_data/output_pc hold an instruction
//   output_ready   in   downstream accepts this cycle
//   output_data    out  [31:0] instruction word
//   output_pc      out  [31:0] address of output_data
module instruction_fetch
   import cpu_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            reset,
   output logic            mem_valid,
   output logic [XLEN-1:0] mem_addr,
   input  logic            mem_ready,
   input  logic [XLEN-1:0] mem_rdata,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            output_valid,
   input  logic            output_ready,
   output logic [XLEN-1:0] output_data,
   output logic [XLEN-1:0] output_pc
);

   fetch_state_t    state, state_n;
   logic [XLEN-1:0] pc, pc_n;
   logic            mem_valid_n;
   logic [XLEN-1:0] mem_addr_n;
   logic            output_valid_n;
   logic [XLEN-1:0] output_data_n;
   logic [XLEN-1:0] output_pc_n;
   logic [XLEN-1:0] redirect_target;

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         pc           <= RESET_PC;
         mem_valid    <= 1'b0;
         mem_addr     <= RESET_PC;
         output_valid <= 1'b0;
         output_data  <= '0;
         output_pc    <= '0;
      end else begin
         state        <= state_n;
         pc           <= pc_n;
         mem_valid    <= mem_valid_n;
         mem_addr     <= mem_addr_n;
         output_valid <= output_valid_n;
         output_data  <= output_data_n;
         output_pc    <= output_pc_n;
      end
   end

   always_comb begin
      state_n         = state;
      pc_n            = pc;
      mem_valid_n     = mem_valid;
      mem_addr_n      = mem_addr;
      output_valid_n  = output_valid;
      output_data_n   = output_data;
      output_pc_n     = output_pc;
      redirect_target = {redirect_pc[XLEN-1:2], 2'b00};

      case (state)
         IDLE: begin
            mem_valid_n = 1'b1;
            mem_addr_n  = redirect_valid ? redirect_target : pc;
            pc_n        = mem_addr_n;
            state_n     = FETCH;
         end

         FETCH: begin
            if (mem_ready && !redirect_valid) begin
               output_data_n  = mem_rdata;
               output_pc_n    = mem_addr;
               output_valid_n = 1'b1;
               mem_valid_n    = 1'b0;
               pc_n           = mem_addr + PC_STEP;
               state_n        = DELIVER;
            end else if (mem_ready) begin
               // Completed read is stale; reissue straight away at the target.
               mem_addr_n = redirect_target;
               pc_n       = redirect_target;
            end else if (redirect_valid) begin
               // The read cannot be cancelled: remember the target and
               // swallow the response when it arrives.
               pc_n    = redirect_target;
               state_n = DISCARD;
            end
         end

         DISCARD: begin
            if (redirect_valid) begin
               pc_n = redirect_target;
            end
            if (mem_ready) begin
               mem_addr_n = redirect_valid ? redirect_target : pc;
               state_n    = FETCH;
            end
         end

         DELIVER: begin
            // A transfer wins over a same-cycle redirect: the instruction has
            // already left, only the next fetch address changes.
            if (output_ready || redirect_valid) begin
               output_valid_n = 1'b0;
               mem_valid_n    = 1'b1;
               mem_addr_n     = redirect_valid ? redirect_target : pc;
               pc_n           = mem_addr_n;
               state_n        = FETCH;
            end
         end

         default: begin
            state_n = IDLE;
         end
      endcase
   end

`ifdef FORMAL
   logic f_past_valid;

   always_ff @(posedge clk) begin
      f_past_valid <= !reset;
   end

   always_ff @(posedge clk) begin
      if (f_past_valid && !reset) begin
         if ($past(mem_valid && !mem_ready)) begin
            assert (mem_valid && (mem_addr == $past(mem_addr)));
         end
         if ($past(output_valid && !output_ready && !redirect_valid)) begin
            assert (output_valid);
            assert (output_data == $past(output_data));
            assert (output_pc == $past(output_pc));
         end
      end
   end

   always_comb begin
      assert (!(mem_valid && output_valid));
      assert (!(state == IDLE && mem_valid));
      assert (output_valid == (state == DELIVER));
   end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - self-checking bench for instruction_fetch
module tb_instruction_fetch;

   localparam logic [31:0] RST_PC = 32'h0000_0100;

   logic        clk;
   logic        reset;
   logic        mem_valid;
   logic [31:0] mem_addr;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        output_valid;
   logic        output_ready;
   logic [31:0] output_data;
   logic [31:0] output_pc;

   int n_vec  = 0;
   int n_miss = 0;
   bit armed  = 0;

   // Transaction-level reference: one outstanding read, a stale flag set by
   // redirects, the next address to fetch, and the held output instruction.
   logic        m_mv, m_ov;
   logic [31:0] m_ma, m_od, m_op, m_next;
   bit          m_stale;

   instruction_fetch #(.RESET_PC(RST_PC)) dut (
      .clk            (clk),
      .reset          (reset),
      .mem_valid      (mem_valid),
      .mem_addr       (mem_addr),
      .mem_ready      (mem_ready),
      .mem_rdata      (mem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .output_valid   (output_valid),
      .output_ready   (output_ready),
      .output_data    (output_data),
      .output_pc      (output_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a - 32'h100) * 32'h0001_0001 + 32'h13;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_step(input bit rst, input bit rdy, input bit redir,
                             input logic [31:0] rpc_raw, input bit ordy);
      logic [31:0] rpc;
      rpc = rpc_raw & 32'hFFFF_FFFC;
      if (rst) begin
         m_mv = 0; m_ov = 0; m_ma = RST_PC; m_od = 0; m_op = 0;
         m_next = RST_PC; m_stale = 0;
      end else if (!m_mv && !m_ov) begin
         m_mv = 1; m_ma = redir ? rpc : m_next; m_next = m_ma; m_stale = 0;
      end else if (m_mv) begin
         if (redir) begin
            m_next  = rpc;
            m_stale = 1;
         end
         if (rdy) begin
            if (m_stale) begin
               m_ma = m_next; m_stale = 0;
            end else begin
               m_ov = 1; m_od = mem_word(m_ma); m_op = m_ma;
               m_mv = 0; m_next = m_ma + 32'd4;
            end
         end
      end else begin
         if (ordy) begin
            m_ov = 0; m_mv = 1; m_ma = redir ? rpc : m_next; m_next = m_ma;
         end else if (redir) begin
            m_ov = 0; m_mv = 1; m_ma = rpc; m_next = rpc;
         end
      end
   endtask

   // Compare at the falling edge, then drive the inputs for the next rising edge.
   task automatic step(input bit rst, input bit rdy, input bit redir,
                       input logic [31:0] rpc, input bit ordy);
      bit rdy_eff;
      @(negedge clk);
      if (armed) begin
         check("mem_valid", 32'(mem_valid), 32'(m_mv));
         check("mem_addr", mem_addr, m_ma);
         check("output_valid", 32'(output_valid), 32'(m_ov));
         check("output_data", output_data, m_od);
         check("output_pc", output_pc, m_op);
      end
      rdy_eff        = rdy && (mem_valid === 1'b1);
      reset          = rst;
      mem_ready      = rdy_eff;
      mem_rdata      = rdy_eff ? mem_word(mem_addr) : $urandom;
      redirect_valid = redir;
      redirect_pc    = rpc;
      output_ready   = ordy;
      model_step(rst, rdy_eff, redir, rpc, ordy);
      armed = 1;
   endtask

   initial begin
      reset = 1; mem_ready = 0; mem_rdata = 0; redirect_valid = 0;
      redirect_pc = 0; output_ready = 0;

      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1);
      check("rst_mem_valid", 32'(mem_valid), 32'd0);
      check("rst_mem_addr", mem_addr, 32'h100);
      check("rst_output_data", output_data, 32'd0);
      step(0, 0, 0, 0, 0);
      check("first_req_valid", 32'(mem_valid), 32'd1);
      check("first_req_addr", mem_addr, 32'h100);
      step(0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         step(0, 0, 0, 0, 0);
         check("bp_output_valid", 32'(output_valid), 32'd1);
         check("bp_output_data", output_data, 32'h13);
         check("bp_output_pc", output_pc, 32'h100);
         check("bp_mem_valid", 32'(mem_valid), 32'd0);
      end
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0);
      check("next_req_addr", mem_addr, 32'h104);
      check("next_req_valid", 32'(mem_valid), 32'd1);
      step(0, 0, 1, 32'h200, 0);
      step(0, 0, 0, 0, 0);
      check("discard_hold_addr", mem_addr, 32'h104);
      step(0, 1, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      check("redir_req_addr", mem_addr, 32'h200);
      check("discard_no_output", 32'(output_valid), 32'd0);
      step(0, 0, 0, 0, 1);
      check("redir_output_pc", output_pc, 32'h200);
      step(0, 1, 1, 32'h200, 0);
      step(0, 0, 0, 0, 0);
      check("same_cycle_redir_addr", mem_addr, 32'h200);
      check("same_cycle_no_output", 32'(output_valid), 32'd0);
      step(0, 1, 0, 0, 0);
      step(0, 0, 1, 32'hFFFF_FFFE, 1);
      step(0, 1, 0, 0, 0);
      check("top_req_addr", mem_addr, 32'hFFFF_FFFC);
      step(0, 0, 0, 0, 1);
      check("top_output_pc", output_pc, 32'hFFFF_FFFC);
      step(0, 0, 0, 0, 0);
      check("wrap_req_addr", mem_addr, 32'h0);
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      check("rst_fetch_mem_valid", 32'(mem_valid), 32'd0);
      check("rst_fetch_output_valid", 32'(output_valid), 32'd0);
      step(0, 1, 0, 0, 0);
      check("refetch_addr", mem_addr, 32'h100);
      step(1, 0, 0, 0, 0);
      check("pre_rst_deliver", 32'(output_valid), 32'd1);
      step(0, 0, 0, 0, 0);
      check("rst_deliver_mem_valid", 32'(mem_valid), 32'd0);
      check("rst_deliver_output_valid", 32'(output_valid), 32'd0);
      step(0, 0, 0, 0, 0);
      check("refetch2_addr", mem_addr, 32'h100);
      check("refetch2_valid", 32'(mem_valid), 32'd1);

      for (int i = 0; i < 4000; i++) begin
         bit          r_rst, r_rdy, r_redir, r_ordy;
         logic [31:0] r_pc;
         r_rst   = ($urandom_range(0, 99) == 0);
         r_rdy   = ($urandom_range(0, 1) == 1);
         r_redir = ($urandom_range(0, 7) == 0);
         r_ordy  = ($urandom_range(0, 3) != 0);
         r_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFC | 32'($urandom_range(0, 3)))
                                               : 32'($urandom);
         step(r_rst, r_rdy, r_redir, r_pc, r_ordy);
      end
      step(0, 0, 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
